// File: rtl/scope_pkg.sv
// Shared definitions for the scope decimator: default widths and the
// shift-and-saturate helper used on the averaging path.
package scope_pkg;

  localparam int DW_DEF = 16;               // default sample width
  localparam int CW_DEF = 17;               // default decimation counter width
  localparam int SW_DEF = DW_DEF + CW_DEF;  // default accumulator width
  localparam int XW     = 64;               // width of the helper arithmetic

  // Arithmetic right shift (floor) of a sign-extended window sum, then
  // clamp into the signed range of a dw-bit sample.
  function automatic logic signed [XW-1:0] sat_shr(
    input logic signed [XW-1:0] sum,
    input int                   shr,
    input int                   dw
  );
    logic signed [XW-1:0] shifted;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    shifted = sum >>> shr;
    hi      = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (dw - 1));
    if (shifted > hi)      sat_shr = hi;
    else if (shifted < lo) sat_shr = lo;
    else                   sat_shr = shifted;
  endfunction

endpackage

// File: rtl/scope_decimator.sv
// Decimating / averaging stage behind the ADC stream input. Collects windows
// of cfg_dec accepted samples and emits either the last sample of the window
// or the shifted, saturated window sum through a one-deep output register.
module scope_decimator
  import scope_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ctl_rst,
  input  logic [CW-1:0] cfg_dec,
  input  logic          cfg_avg,
  input  logic [4:0]    cfg_shr,
  input  logic [DW-1:0] sti_tdata,
  input  logic          sti_tlast,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  output logic [DW-1:0] sto_tdata,
  output logic          sto_tlast,
  output logic          sto_tvalid,
  input  logic          sto_tready
);

  // Accumulator wide enough for a full window of full-scale samples.
  localparam int SW = DW + CW;

  // Window state and configuration shadow.
  logic [CW-1:0]        r_cnt;
  logic signed [SW-1:0] r_sum;
  logic [CW-1:0]        r_dec_s;
  logic                 r_avg_s;
  logic [4:0]           r_shr_s;

  // Output register.
  logic                 r_valid;
  logic [DW-1:0]        r_data;
  logic                 r_last;

  logic                 w_accept;
  logic                 w_first;
  logic                 w_close;
  logic [CW-1:0]        w_dec_in;
  logic [CW-1:0]        w_dec;
  logic                 w_avg;
  logic [4:0]           w_shr;
  int                   w_shr_amt;
  logic signed [SW-1:0] w_sample_ext;
  logic signed [SW-1:0] w_sum_next;
  logic [DW-1:0]        w_avg_val;
  logic [DW-1:0]        w_result;

  // Input is blocked only while a held output waits for the consumer.
  assign sti_tready = ~r_valid | sto_tready;
  assign w_accept   = sti_tvalid & sti_tready;
  assign w_first    = (r_cnt == '0);

  assign sto_tdata  = r_data;
  assign sto_tlast  = r_last;
  assign sto_tvalid = r_valid;

  // Effective window config: live inputs on the opening beat, shadow afterwards.
  // NOTE: every signal driven here gets a default first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_dec_in = (cfg_dec == '0) ? CW'(1) : cfg_dec;
    w_dec    = r_dec_s;
    w_avg    = r_avg_s;
    w_shr    = r_shr_s;
    if (w_first) begin
      w_dec = w_dec_in;
      w_avg = cfg_avg;
      w_shr = cfg_shr;
    end
  end

  // Window close decision, running sum and result selection for the current beat.
  always_comb begin
    w_close      = (r_cnt == w_dec - CW'(1)) | sti_tlast;
    w_sample_ext = {{(SW-DW){sti_tdata[DW-1]}}, sti_tdata};
    // The opening beat ignores whatever is left in r_sum.
    w_sum_next   = w_first ? w_sample_ext : r_sum + w_sample_ext;
    w_shr_amt    = (int'(w_shr) > SW - 1) ? SW - 1 : int'(w_shr);
    w_avg_val    = DW'(sat_shr({{(XW-SW){w_sum_next[SW-1]}}, w_sum_next}, w_shr_amt, DW));
    w_result     = w_avg ? w_avg_val : sti_tdata;
  end

  // Window counter, accumulator and config shadow registers.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_dec_s <= CW'(1);
      r_avg_s <= 1'b0;
      r_shr_s <= '0;
    end else if (ctl_rst) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_dec_s <= w_dec_in;
      r_avg_s <= cfg_avg;
      r_shr_s <= cfg_shr;
    end else if (w_accept) begin
      if (w_first) begin
        r_dec_s <= w_dec_in;
        r_avg_s <= cfg_avg;
        r_shr_s <= cfg_shr;
      end
      if (w_close) begin
        r_cnt <= '0;
        r_sum <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_sum <= w_sum_next;
      end
    end
  end

  // One-deep output register: loads on window close, holds under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (ctl_rst) begin
      r_valid <= 1'b0;
    end else if (w_accept && w_close) begin
      r_valid <= 1'b1;
      r_data  <= w_result;
      r_last  <= sti_tlast;
    end else if (sto_tready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
